// File: rtl/mac_maxpool.sv
// mac_maxpool: streaming 2x2, stride-2 max pooling over a MAP_W x MAP_H
// feature map arriving in raster order from a MAC array. Even-row pair
// maxima are parked in a half-width line buffer; the odd row completes
// each window and emits one registered result one cycle later.
module mac_maxpool #(
  parameter int DATA_W = 10,
  parameter int MAP_W  = 4,
  parameter int MAP_H  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_OFM,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              frame_done
);

  localparam int COL_W = $clog2(MAP_W);
  localparam int ROW_W = $clog2(MAP_H);
  localparam int LB_N  = MAP_W / 2;
  localparam int IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;

  // Position within the frame of the next accepted sample.
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  // Even-column sample waiting for its odd-column partner.
  logic [DATA_W-1:0] pair_q, pair_d;
  // One entry per window column: max of the two samples from the even row.
  logic [DATA_W-1:0] lbuf_q [LB_N];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              frame_done_q, frame_done_d;

  logic              col_last, row_last;
  logic              lb_we;
  logic [IDX_W-1:0]  lb_idx;
  logic [DATA_W-1:0] pair_max, win_max;

  assign col_last = (col_q == COL_W'(MAP_W - 1));
  assign row_last = (row_q == ROW_W'(MAP_H - 1));
  assign lb_idx   = IDX_W'(col_q >> 1);
  assign pair_max = (in_OFM > pair_q) ? in_OFM : pair_q;
  assign win_max  = (lbuf_q[lb_idx] > pair_max) ? lbuf_q[lb_idx] : pair_max;

  // Next-state decode: counters, pair capture, line-buffer write and output.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it
    // unassigned; a missing default here would infer a latch.
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    lb_we        = 1'b0;
    out_valid_d  = 1'b0;
    out_d        = '0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        pair_d = in_OFM;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_d        = win_max;
        frame_done_d = col_last && row_last;
      end
    end
  end

  // Frame position, pair register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer written with the even-row pair maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer is small and flop-based, so clearing it on reset
      // is cheap and keeps its contents deterministic after power-up.
      for (int i = 0; i < LB_N; i++) lbuf_q[i] <= '0;
    end else if (lb_we) begin
      lbuf_q[lb_idx] <= pair_max;
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign frame_done = frame_done_q;

endmodule
